// File: rtl/shifter_pkg.sv
// shifter_pkg: op encodings, op class helpers and the
// mapping of mux levels onto pipeline register stages.
package shifter_pkg;

    localparam logic [2:0] OP_SRA  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SLL2 = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;

    // register stage that holds mux level k
    function automatic int lvl_stage(input int k, input int stages,
                                     input int shw);
        return (k * stages) / shw;
    endfunction

    // first mux level placed in stage s
    function automatic int first_lvl(input int s, input int stages,
                                     input int shw);
        int n;
        n = 0;
        for (int k = 0; k < shw; k++) begin
            if (lvl_stage(k, stages, shw) < s) n++;
        end
        return n;
    endfunction

    function automatic logic op_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SLL2) || (op == OP_ROL);
    endfunction

    function automatic logic op_rot(input logic [2:0] op);
        return (op == OP_ROR) || (op == OP_ROL);
    endfunction

    // reserved 11x codes fall through to SRL
    function automatic logic op_arith(input logic [2:0] op);
        return op == OP_SRA;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: one pipeline stage holding NUM_LVL mux levels
// starting at FIRST_LVL, plus valid and payload registers.
// Ports: src_valid_i/adv_i handshake in, payload in (data,
// shamt, op, carry), valid_o/load_o, registered payload out,
// zero_o = mux result is zero (feeds the output zero flag).
module shifter_stage #(
    parameter int WIDTH     = 32,
    parameter int SHW       = 5,
    parameter int FIRST_LVL = 0,
    parameter int NUM_LVL   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             src_valid_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [2:0]       op_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic             load_o,
    output logic             zero_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   shamt_o,
    output logic [2:0]       op_o,
    output logic             carry_o
);
    import shifter_pkg::*;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] mux;

    function automatic logic [WIDTH-1:0] lvl_shift(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       op,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        if (op_rot(op) && op_left(op)) begin
            r = (x << amt) | (x >> (WIDTH - amt));
        end else if (op_rot(op)) begin
            r = (x >> amt) | (x << (WIDTH - amt));
        end else if (op_left(op)) begin
            r = x << amt;
        end else if (op_arith(op)) begin
            // msb is preserved by every level, so it stays the sign
            r = $signed(x) >>> amt;
        end else begin
            r = x >> amt;
        end
        return r;
    endfunction

    always_comb begin
        mux = data_i;
        for (int j = 0; j < NUM_LVL; j++) begin
            if (shamt_i[FIRST_LVL + j]) begin
                mux = lvl_shift(mux, op_i, 1 << (FIRST_LVL + j));
            end
        end
    end

    assign load_o = adv_i && src_valid_i && !flush;
    assign zero_o = (mux == '0);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        carry_d = carry_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (adv_i) begin
            valid_d = src_valid_i;
        end
        // payload only moves when a real op enters the stage
        if (load_o) begin
            data_d  = mux;
            shamt_d = shamt_i;
            op_d    = op_i;
            carry_d = carry_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter (SRA/SRL/SLL/ROR/ROL)
// with carry-out and zero flag, STAGES register stages.
// Ports: clk, rst (async high), flush; in_valid/in_ready with
// in_a, in_shamt, in_op; out_valid/out_ready with out_data,
// out_carry, out_zero.
module shifter_pipe #(
    parameter int  WIDTH  = 32,
    parameter int  STAGES = 2,
    localparam int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);
    import shifter_pkg::*;

    logic [STAGES:0]   adv;
    logic [STAGES-1:0] vq, cq, load_w, zero_c;
    logic [STAGES-1:0] src_v, src_c;
    logic [WIDTH-1:0]  src_d [STAGES];
    logic [SHW-1:0]    src_s [STAGES];
    logic [2:0]        src_o [STAGES];
    logic [WIDTH-1:0]  dq [STAGES];
    logic [SHW-1:0]    sq [STAGES];
    logic [2:0]        oq [STAGES];
    logic [SHW-1:0]    sh_m1, sh_neg;
    logic              carry0;
    logic              zero_q, zero_d;
    logic              unused_w;

    // a stage can take new work if empty or its successor moves
    always_comb begin
        adv[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = !vq[i] || adv[i+1];
        end
    end

    assign in_ready = adv[0] && !flush && !rst;

    // carry depends only on operand and amount, so it is
    // resolved up front and rides along with the data
    always_comb begin
        sh_m1  = in_shamt - SHW'(1);
        sh_neg = SHW'(0) - in_shamt;
        carry0 = 1'b0;
        if (in_shamt != '0) begin
            carry0 = op_left(in_op) ? in_a[sh_neg] : in_a[sh_m1];
        end
    end

    always_comb begin
        src_v[0] = in_valid && in_ready;
        src_c[0] = carry0;
        src_d[0] = in_a;
        src_s[0] = in_shamt;
        src_o[0] = in_op;
        for (int i = 1; i < STAGES; i++) begin
            src_v[i] = vq[i-1];
            src_c[i] = cq[i-1];
            src_d[i] = dq[i-1];
            src_s[i] = sq[i-1];
            src_o[i] = oq[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int FL = first_lvl(g, STAGES, SHW);
        localparam int NL = first_lvl(g + 1, STAGES, SHW) - FL;
        shifter_stage #(
            .WIDTH(WIDTH), .SHW(SHW),
            .FIRST_LVL(FL), .NUM_LVL(NL)
        ) u_stage (
            .clk(clk), .rst(rst), .flush(flush),
            .src_valid_i(src_v[g]), .adv_i(adv[g]),
            .data_i(src_d[g]), .shamt_i(src_s[g]),
            .op_i(src_o[g]), .carry_i(src_c[g]),
            .valid_o(vq[g]), .load_o(load_w[g]),
            .zero_o(zero_c[g]), .data_o(dq[g]),
            .shamt_o(sq[g]), .op_o(oq[g]), .carry_o(cq[g])
        );
    end

    always_comb begin
        zero_d = zero_q;
        if (load_w[STAGES-1]) zero_d = zero_c[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) zero_q <= 1'b0;
        else     zero_q <= zero_d;
    end

    assign out_valid = vq[STAGES-1];
    assign out_data  = dq[STAGES-1];
    assign out_carry = cq[STAGES-1];
    assign out_zero  = zero_q;

    // last-stage shamt/op and early-stage flags have no consumer
    assign unused_w = ^{zero_c, load_w, sq[STAGES-1], oq[STAGES-1]};

endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: directed table, handshake corner cases and
// random streams on three shifter_pipe configurations.
module tb_shifter_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        iv32, ir32, ov32, or32, oc32, oz32, fl32;
    logic [31:0] a32, od32;
    logic [4:0]  sh32;
    logic [2:0]  op32;

    logic        iv8, ir8, ov8, or8, oc8, oz8, fl8;
    logic [7:0]  a8, od8;
    logic [2:0]  sh8, op8;

    logic        iv64, ir64, ov64, or64, oc64, oz64, fl64;
    logic [63:0] a64, od64;
    logic [5:0]  sh64;
    logic [2:0]  op64;

    shifter_pipe #(.WIDTH(32), .STAGES(2)) u32 (
        .clk(clk), .rst(rst), .flush(fl32),
        .in_valid(iv32), .in_ready(ir32), .in_a(a32),
        .in_shamt(sh32), .in_op(op32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32),
        .out_carry(oc32), .out_zero(oz32)
    );

    shifter_pipe #(.WIDTH(8), .STAGES(3)) u8 (
        .clk(clk), .rst(rst), .flush(fl8),
        .in_valid(iv8), .in_ready(ir8), .in_a(a8),
        .in_shamt(sh8), .in_op(op8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8),
        .out_carry(oc8), .out_zero(oz8)
    );

    shifter_pipe #(.WIDTH(64), .STAGES(1)) u64 (
        .clk(clk), .rst(rst), .flush(fl64),
        .in_valid(iv64), .in_ready(ir64), .in_a(a64),
        .in_shamt(sh64), .in_op(op64),
        .out_valid(ov64), .out_ready(or64), .out_data(od64),
        .out_carry(oc64), .out_zero(oz64)
    );

    // expected results in flight, per DUT: {zero, carry, data}
    logic [65:0] sb [3][$];
    logic [65:0] held [3];
    logic        held_v [3];
    int          done_cnt [3];

    task automatic check(input string nm, input logic [71:0] got,
                         input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // reference: each result bit picked from its source bit
    function automatic logic [65:0] model(input logic [2:0] op,
        input logic [63:0] a, input int s, input int w);
        logic [63:0] r;
        logic        c;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                3'b001, 3'b011: if (i >= s) r[i] = a[i-s];
                3'b100: r[i] = a[(i+s) % w];
                3'b101: r[i] = a[(i-s+w) % w];
                3'b000: begin
                    if (i + s < w) r[i] = a[i+s];
                    else r[i] = a[w-1];
                end
                default: if (i + s < w) r[i] = a[i+s];
            endcase
        end
        c = 1'b0;
        if (s != 0) begin
            case (op)
                3'b001, 3'b011: c = a[w-s];
                3'b100: c = r[w-1];
                3'b101: c = r[0];
                default: c = a[s-1];
            endcase
        end
        return {r == 64'd0, c, r};
    endfunction

    task automatic mon(input int id, input int w,
        input logic iv, input logic ir, input logic [63:0] a,
        input int sh, input logic [2:0] op, input logic ov,
        input logic ordy, input logic [63:0] od, input logic oc,
        input logic oz, input logic fl);
        logic [65:0] got;
        got = {oz, oc, od};
        if (rst) begin
            sb[id].delete();
            held_v[id] = 1'b0;
            check($sformatf("rst_out/w%0d", w), 72'({ov, got}), 72'(0));
            check($sformatf("rst_ready/w%0d", w), 72'(ir), 72'(0));
            return;
        end
        if (held_v[id]) begin
            check($sformatf("stall_hold/w%0d", w), 72'({ov, got}),
                  72'({1'b1, held[id]}));
        end
        held_v[id] = ov && !ordy && !fl;
        held[id]   = got;
        if (ov && ordy) begin
            total++;
            if (sb[id].size() == 0) begin
                bad++;
                $display("FAIL spurious_out/w%0d: got data %h expected none",
                         w, od);
            end else begin
                total--;
                done_cnt[id]++;
                check($sformatf("result/w%0d", w), 72'(got),
                      72'(sb[id].pop_front()));
            end
        end
        if (fl) begin
            check($sformatf("flush_ready/w%0d", w), 72'(ir), 72'(0));
            sb[id].delete();
        end else if (iv && ir) begin
            sb[id].push_back(model(op, a, sh, w));
        end
    endtask

    always @(negedge clk)
        mon(0, 32, iv32, ir32, 64'(a32), int'(sh32), op32, ov32, or32,
            64'(od32), oc32, oz32, fl32);
    always @(negedge clk)
        mon(1, 8, iv8, ir8, 64'(a8), int'(sh8), op8, ov8, or8,
            64'(od8), oc8, oz8, fl8);
    always @(negedge clk)
        mon(2, 64, iv64, ir64, a64, int'(sh64), op64, ov64, or64,
            od64, oc64, oz64, fl64);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] d;
        logic        c;
        logic        z;
    } vec_t;

    vec_t        tbl [13];
    logic [65:0] exp_r;

    initial begin
        int n;
        int k;
        int base;
        logic saw_block;

        tbl[0]  = '{3'b000, 32'h80000010, 5'd4,  32'hF8000001, 1'b0, 1'b0};
        tbl[1]  = '{3'b001, 32'h80000001, 5'd1,  32'h00000002, 1'b1, 1'b0};
        tbl[2]  = '{3'b010, 32'h00000001, 5'd1,  32'h00000000, 1'b1, 1'b1};
        tbl[3]  = '{3'b100, 32'h00000001, 5'd1,  32'h80000000, 1'b1, 1'b0};
        tbl[4]  = '{3'b101, 32'h80000000, 5'd31, 32'h40000000, 1'b0, 1'b0};
        tbl[5]  = '{3'b000, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 1'b0};
        tbl[6]  = '{3'b101, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0};
        tbl[7]  = '{3'b110, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};
        tbl[8]  = '{3'b011, 32'h0000000F, 5'd28, 32'hF0000000, 1'b0, 1'b0};
        tbl[9]  = '{3'b000, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b1, 1'b1};
        tbl[10] = '{3'b001, 32'h00000003, 5'd31, 32'h80000000, 1'b1, 1'b0};
        tbl[11] = '{3'b100, 32'h0000000F, 5'd4,  32'hF0000000, 1'b1, 1'b0};
        tbl[12] = '{3'b111, 32'hFFFFFFFF, 5'd16, 32'h0000FFFF, 1'b1, 1'b0};

        held_v = '{1'b0, 1'b0, 1'b0};
        {iv32, fl32, a32, sh32, op32} = '0;  or32 = 1'b1;
        {iv8, fl8, a8, sh8, op8}      = '0;  or8  = 1'b1;
        {iv64, fl64, a64, sh64, op64} = '0;  or64 = 1'b1;

        // asynchronous reset before any clock edge
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_state", 72'({ov32, od32, oc32, oz32, ir32}), 72'(0));
        check("reset_state64", 72'({ov64, od64, oc64, oz64}), 72'(0));
        repeat (3) step();
        rst = 1'b0;
        #1 check("ready_after_rst", 72'({ir32, ir8, ir64}), 72'(3'b111));
        step();

        // directed table: latency and exact values
        for (int i = 0; i < 13; i++) begin
            op32 = tbl[i].op; a32 = tbl[i].a; sh32 = tbl[i].sh;
            iv32 = 1'b1;
            check($sformatf("idle_ready[%0d]", i), 72'(ir32), 72'(1));
            step();
            iv32 = 1'b0;
            n = 1;
            while (!ov32 && n < 8) begin
                step();
                n++;
            end
            check($sformatf("latency[%0d]", i), 72'(n), 72'(2));
            check($sformatf("vec[%0d]", i), 72'({ov32, oz32, oc32, od32}),
                  72'({1'b1, tbl[i].z, tbl[i].c, tbl[i].d}));
            step();
        end

        // 8 back-to-back ops, downstream stalls on cycles 3..6
        k = 0;
        saw_block = 1'b0;
        base = done_cnt[0];
        for (int cyc = 0; cyc < 40 && (k < 8 || sb[0].size() != 0);
             cyc++) begin
            or32 = !(cyc >= 3 && cyc <= 6);
            iv32 = (k < 8);
            a32  = $urandom;
            sh32 = 5'($urandom);
            op32 = 3'($urandom);
            #3;
            if (iv32 && !ir32) saw_block = 1'b1;
            if (iv32 && ir32) k++;
            step();
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        check("stall_in_ready_drop", 72'(saw_block), 72'(1));
        check("stall_accepted", 72'(k), 72'(8));
        check("stall_delivered", 72'(done_cnt[0] - base), 72'(8));
        repeat (3) step();

        // flush with in_valid high: oldest op leaves, younger dies
        a32 = 32'h00F0_0000; sh32 = 5'd4; op32 = 3'b010; iv32 = 1'b1;
        step();
        a32 = 32'h0000_0F00; sh32 = 5'd8; op32 = 3'b001;
        step();
        fl32 = 1'b1;
        a32 = 32'h1234_5678;
        #3 check("flush_blocks_in", 72'(ir32), 72'(0));
        step();
        fl32 = 1'b0;
        iv32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_no_out[%0d]", i), 72'(ov32), 72'(0));
            step();
        end

        // flush while the output is stalled
        or32 = 1'b0;
        iv32 = 1'b1; a32 = 32'hAAAA_5555; op32 = 3'b100; sh32 = 5'd7;
        step();
        op32 = 3'b101;
        step();
        iv32 = 1'b0;
        fl32 = 1'b1;
        step();
        fl32 = 1'b0;
        or32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("flush_stall_no_out[%0d]", i), 72'(ov32), 72'(0));
            step();
        end

        // pipeline is usable right after a flush
        a32 = 32'h8000_0003; sh32 = 5'd2; op32 = 3'b000; iv32 = 1'b1;
        exp_r = model(3'b000, 64'(32'h8000_0003), 2, 32);
        step();
        iv32 = 1'b0;
        n = 1;
        while (!ov32 && n < 8) begin
            step();
            n++;
        end
        check("post_flush_op", 72'({ov32, oz32, oc32, od32}),
              72'({1'b1, exp_r[65:64], exp_r[31:0]}));
        step();

        // async reset between edges with results in flight
        a32 = 32'hFFFF_FFFF; sh32 = 5'd3; op32 = 3'b100; iv32 = 1'b1;
        repeat (3) step();
        iv32 = 1'b0;
        check("pre_rst_busy", 72'({ov32, od32 != 0}), 72'(2'b11));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out", 72'({ov32, od32, oc32, oz32, ir32}), 72'(0));
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst_release_ready", 72'(ir32), 72'(1));
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rst_no_out[%0d]", i), 72'(ov32), 72'(0));
        end

        // random streams on all three configurations
        base = done_cnt[1];
        for (int cyc = 0; cyc < 15000; cyc++) begin
            iv32 = ($urandom_range(0, 9) != 0);
            a32  = $urandom;
            sh32 = 5'($urandom);
            op32 = 3'($urandom);
            or32 = ($urandom_range(0, 4) != 0);
            fl32 = ($urandom_range(0, 99) == 0);
            iv8  = ($urandom_range(0, 9) != 0);
            a8   = 8'($urandom);
            sh8  = 3'($urandom);
            op8  = 3'($urandom);
            or8  = ($urandom_range(0, 4) != 0);
            iv64 = ($urandom_range(0, 9) != 0);
            a64  = {$urandom, $urandom};
            sh64 = 6'($urandom);
            op64 = 3'($urandom);
            or64 = ($urandom_range(0, 4) != 0);
            step();
        end
        {iv32, iv8, iv64, fl32} = '0;
        {or32, or8, or64} = 3'b111;
        repeat (8) step();
        check("drain_w32", 72'(sb[0].size()), 72'(0));
        check("drain_w8", 72'(sb[1].size()), 72'(0));
        check("drain_w64", 72'(sb[2].size()), 72'(0));
        check("random_w8_volume", 72'(done_cnt[1] - base > 10000), 72'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
